radix3_commutator: RTL and testbench
====================================

Name: radix3_commutator

Overview:
- Input-side counterpart of the radix-3 output shuffler in the Radix-3^2 FFT pipeline.
- Takes a single serial complex sample stream and regroups it into three parallel lanes.
- For each n in 0..DEPTH-1 it presents the butterfly triplet (x[n], x[n+DEPTH], x[n+2*DEPTH]) of a 3*DEPTH-sample frame.
- Owns its own frame counter and buffering; no external select lines.

Parameters:
- WIDTH, 32, sample width (16-bit real in [31:16], 16-bit imag in [15:0]); passed through unmodified.
- DEPTH, 81, lane span = frame length / 3; any value >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  WIDTH  serial input sample.
- din_valid  input  1  din carries a sample this cycle.
- sof  input  1  start of frame; qualified by din_valid.
- a_out  output  WIDTH  lane 0 sample x[n].
- b_out  output  WIDTH  lane 1 sample x[n+DEPTH].
- c_out  output  WIDTH  lane 2 sample x[n+2*DEPTH].
- out_valid  output  1  triplet valid this cycle.
- out_first  output  1  triplet n=0 of frame.
- out_last  output  1  triplet n=DEPTH-1 of frame.
- frame_err  output  1  one-cycle pulse: sof arrived misaligned.

Behaviour:
- State: phase (0..2) and idx (0..DEPTH-1). Two buffers buf0, buf1, each DEPTH x WIDTH.
- Reset (rst_n=0 at clk edge): phase=0, idx=0; a_out, b_out, c_out = 0; out_valid, out_first, out_last, frame_err = 0. Buffer contents are don't-care.
- Reset mid-frame discards the partial frame. The next valid sample is x[0] of a new frame.
- State advances only on din_valid=1. With din_valid=0, phase, idx and buffers hold and out_valid=0. Gaps of any length are legal.
- Counter: on a valid sample, idx+1. At idx=DEPTH-1, idx wraps to 0 and phase+1; phase 2 wraps to 0.
- Phase 0, valid sample: buf0[idx] <= din; no output.
- Phase 1, valid sample: buf1[idx] <= din; no output.
- Phase 2, valid sample, registered with latency 1 cycle after the din_valid edge:
  - a_out <= buf0[idx], b_out <= buf1[idx], c_out <= din;
  - out_valid <= 1; out_first <= (idx==0); out_last <= (idx==DEPTH-1).
- Cycles without an output: out_valid, out_first, out_last = 0; a/b/c_out hold their last value.
- Throughput: one sample in per clock sustained. Output duty is 1/3 per frame (DEPTH triplets per 3*DEPTH inputs).
- Frames run back-to-back with no bubble.
- sof handling (only when din_valid=1):
  - The sample is treated as phase 0, idx 0 and written to buf0[0]. The counter continues from there.
  - If the state was not (phase 0, idx 0), frame_err=1 for exactly the next cycle. The partial frame is dropped and no triplets are emitted for it.
  - sof with din_valid=0 is ignored.
- sof is optional: with sof tied low, frames are delimited by the counter from reset.
- DEPTH=1: each sample advances the phase; triplet (x0, x1, x2) is emitted after the third sample with out_first=out_last=1.
- No arithmetic; data bits pass bit-exact. No overflow is possible.

Test Plan:
- DEPTH=3, reset, then din=1..9 back-to-back with sof on din=1 -> out_valid on 3 cycles: (1,4,7) with first=1, (2,5,8), (3,6,9) with last=1. Each triplet appears 1 cycle after din=7, 8, 9 respectively; frame_err stays 0.
- DEPTH=3, same frame with din_valid low for 2 cycles after every sample -> identical triplets, each 1 cycle after its phase-2 input; out_valid=0 during gaps; outputs hold.
- DEPTH=3, two frames 1..9 and 11..19 back-to-back -> (1,4,7),(2,5,8),(3,6,9) then (11,14,17),(12,15,18),(13,16,19) with no stall.
- DEPTH=3, sof on din=1, then sof again on din=5 (phase 1, idx 1) -> frame_err pulse 1 cycle; din=5..13 then yield (5,8,11),(6,9,12),(7,10,13).
- DEPTH=3, rst_n=0 for one cycle after din=6, then din=21..29 -> all outputs 0 after reset; triplets (21,24,27),(22,25,28),(23,26,29); no stale data.
- DEPTH=81, WIDTH=32, random 243-sample frame -> 81 triplets equal to (x[n], x[n+81], x[n+162]); first at n=0, last at n=80.

Source files
------------

// File: rtl/radix3_commutator.sv
`default_nettype none
// ============================================================================
// Module      : radix3_commutator
// Description : Input-side commutator for a radix-3^2 FFT pipeline. Regroups a
//               serial complex sample stream into the butterfly triplets
//               (x[n], x[n+DEPTH], x[n+2*DEPTH]) of each 3*DEPTH-sample frame.
//               The first two thirds of a frame are parked in two DEPTH-deep
//               buffers; each sample of the last third releases one triplet.
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               din        - serial sample ({re[31:16], im[15:0]} for WIDTH=32)
//               din_valid  - din carries a sample this cycle
//               sof        - start of frame, qualified by din_valid
//               a_out      - lane 0, x[n]
//               b_out      - lane 1, x[n+DEPTH]
//               c_out      - lane 2, x[n+2*DEPTH]
//               out_valid  - triplet valid this cycle
//               out_first  - triplet n=0
//               out_last   - triplet n=DEPTH-1
//               frame_err  - one-cycle pulse, sof arrived misaligned
// Revision    : 1.0 - initial release
// ============================================================================
module radix3_commutator #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 81
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             frame_err
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);

    // Frame phase: which third of the frame the current sample belongs to.
    localparam logic [1:0] c_PH0 = 2'd0;
    localparam logic [1:0] c_PH1 = 2'd1;
    localparam logic [1:0] c_PH2 = 2'd2;

    logic [1:0]         r_phase;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_buf0 [0:DEPTH-1];
    logic [WIDTH-1:0]   r_buf1 [0:DEPTH-1];

    logic [WIDTH-1:0]   r_a_out;
    logic [WIDTH-1:0]   r_b_out;
    logic [WIDTH-1:0]   r_c_out;
    logic               r_out_valid;
    logic               r_out_first;
    logic               r_out_last;
    logic               r_frame_err;

    logic               w_sof_hit;
    logic               w_misalign;
    logic [1:0]         w_cur_phase;
    logic [c_IDX_W-1:0] w_cur_idx;
    logic [1:0]         w_nxt_phase;
    logic [c_IDX_W-1:0] w_nxt_idx;
    logic               w_emit;

    // A qualified sof re-anchors the sample at (phase 0, idx 0) regardless of
    // where the counter was; anything collected before it is abandoned.
    assign w_sof_hit   = din_valid & sof;
    assign w_misalign  = w_sof_hit & ((r_phase != c_PH0) | (r_idx != '0));
    assign w_cur_phase = w_sof_hit ? c_PH0 : r_phase;
    assign w_cur_idx   = w_sof_hit ? '0 : r_idx;
    assign w_emit      = din_valid & (w_cur_phase == c_PH2);

    always_comb begin
        w_nxt_phase = w_cur_phase;
        w_nxt_idx   = w_cur_idx + c_IDX_W'(1);
        if (w_cur_idx == c_LAST_IDX) begin
            w_nxt_idx = '0;
            case (w_cur_phase)
                c_PH0:   w_nxt_phase = c_PH1;
                c_PH1:   w_nxt_phase = c_PH2;
                default: w_nxt_phase = c_PH0;
            endcase
        end
    end

    // Buffer storage needs no reset: every entry is rewritten in phase 0/1
    // before it is read in phase 2 of the same frame.
    always_ff @(posedge clk) begin
        if (din_valid && (w_cur_phase == c_PH0)) begin
            r_buf0[w_cur_idx] <= din;
        end
        if (din_valid && (w_cur_phase == c_PH1)) begin
            r_buf1[w_cur_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase     <= c_PH0;
            r_idx       <= '0;
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_c_out     <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_misalign;
            r_out_valid <= w_emit;
            r_out_first <= w_emit & (w_cur_idx == '0);
            r_out_last  <= w_emit & (w_cur_idx == c_LAST_IDX);
            // Lane data holds between triplets.
            if (w_emit) begin
                r_a_out <= r_buf0[w_cur_idx];
                r_b_out <= r_buf1[w_cur_idx];
                r_c_out <= din;
            end
            if (din_valid) begin
                r_phase <= w_nxt_phase;
                r_idx   <= w_nxt_idx;
            end
        end
    end

    assign a_out     = r_a_out;
    assign b_out     = r_b_out;
    assign c_out     = r_c_out;
    assign out_valid = r_out_valid;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_radix3_commutator.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix3_commutator
// Description : Self-checking bench for radix3_commutator. One instance with
//               DEPTH=3 for the directed frames and one with DEPTH=81 for a
//               random full-size frame; both share the stimulus and a select
//               picks which one is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix3_commutator;

    typedef struct {
        logic [31:0] din;
        bit          vld;
        bit          sof;
        bit          err;   // frame_err expected on the following cycle
        bit          ov;    // this sample releases a triplet
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        bit          f;
        bit          l;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        f;
        logic        l;
    } trip_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        din_valid;
    logic        sof;
    bit          sel81;

    logic [31:0] a3, b3, c3, a81, b81, c81;
    logic        ov3, f3, l3, e3, ov81, f81, l81, e81;
    logic [31:0] m_a, m_b, m_c;
    logic        m_ov, m_f, m_l, m_err;

    int    checks = 0;
    int    errors = 0;
    vec_t  tbl[$];
    trip_t sb[$];
    trip_t held;

    always #5 clk = ~clk;

    radix3_commutator #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
        .a_out(a3), .b_out(b3), .c_out(c3), .out_valid(ov3),
        .out_first(f3), .out_last(l3), .frame_err(e3)
    );

    radix3_commutator #(.WIDTH(32), .DEPTH(81)) u_d81 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
        .a_out(a81), .b_out(b81), .c_out(c81), .out_valid(ov81),
        .out_first(f81), .out_last(l81), .frame_err(e81)
    );

    always_comb begin
        m_a   = sel81 ? a81  : a3;
        m_b   = sel81 ? b81  : b3;
        m_c   = sel81 ? c81  : c3;
        m_ov  = sel81 ? ov81 : ov3;
        m_f   = sel81 ? f81  : f3;
        m_l   = sel81 ? l81  : l3;
        m_err = sel81 ? e81  : e3;
    end

    function automatic vec_t mk(input logic [31:0] d, input bit v, input bit s,
                                input bit e, input bit o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c,
                                input bit f, input bit l);
        vec_t r;
        r.din = d; r.vld = v; r.sof = s; r.err = e; r.ov = o;
        r.a = a; r.b = b; r.c = c; r.f = f; r.l = l;
        return r;
    endfunction

    // One DEPTH=3 frame of values base+1..base+9; 'gap' idle cycles follow
    // each sample, with sof and junk data asserted while din_valid is low.
    task automatic add_frame(input int base, input int gap);
        for (int k = 1; k <= 9; k++) begin
            tbl.push_back(mk(base + k, 1, k == 1, 0, k >= 7, base + k - 6,
                             base + k - 3, base + k, k == 7, k == 9));
            for (int g = 0; g < gap; g++)
                tbl.push_back(mk(32'hDEAD_0000 + k, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic step(input vec_t v);
        trip_t got, exp;
        din = v.din; din_valid = v.vld; sof = v.sof;
        if (v.vld && v.ov) sb.push_back('{v.a, v.b, v.c, v.f, v.l});
        @(posedge clk);
        #1;
        checks++;
        if (m_err !== v.err) begin
            errors++;
            $display("FAIL frame_err din=%0d got=%b exp=%b", v.din, m_err, v.err);
        end
        if (m_ov === 1'b1) begin
            checks++;
            got = '{m_a, m_b, m_c, m_f, m_l};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_triplet din=%0d got=(%0d,%0d,%0d) exp=none",
                         v.din, m_a, m_b, m_c);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL triplet din=%0d got=(%0d,%0d,%0d f%b l%b) exp=(%0d,%0d,%0d f%b l%b)",
                             v.din, got.a, got.b, got.c, got.f, got.l,
                             exp.a, exp.b, exp.c, exp.f, exp.l);
                end
                held = exp;
            end
        end else begin
            checks++;
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                errors++;
                $display("FAIL missing_triplet din=%0d got=out_valid %b exp=(%0d,%0d,%0d)",
                         v.din, m_ov, exp.a, exp.b, exp.c);
            end
            checks++;
            if ({m_f, m_l} !== 2'b00 || {m_a, m_b, m_c} !== {held.a, held.b, held.c}) begin
                errors++;
                $display("FAIL hold din=%0d got=(%0d,%0d,%0d f%b l%b) exp=(%0d,%0d,%0d f0 l0)",
                         v.din, m_a, m_b, m_c, m_f, m_l, held.a, held.b, held.c);
            end
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; din_valid = 1'b0; sof = 1'b0; din = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        checks++;
        if ({m_ov, m_f, m_l, m_err, m_a, m_b, m_c} !== '0) begin
            errors++;
            $display("FAIL reset got=(%0d,%0d,%0d v%b f%b l%b e%b) exp=all zero",
                     m_a, m_b, m_c, m_ov, m_f, m_l, m_err);
        end
        rst_n = 1'b1;
        sb.delete();
        held = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] x [243];
        rst_n = 1'b1; din = '0; din_valid = 1'b0; sof = 1'b0; sel81 = 1'b0;
        held = '0;

        // Back-to-back frame, then the same frame with 2-cycle gaps.
        do_reset();
        add_frame(0, 0);
        add_frame(0, 2);
        run_table();

        // Two frames with no bubble between them.
        add_frame(0, 0);
        add_frame(10, 0);
        run_table();

        // Misaligned sof at phase 1, idx 1.
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(k, 1, k == 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 5; k <= 13; k++)
            tbl.push_back(mk(k, 1, k == 5, k == 5, k >= 11, k - 6, k - 3, k,
                             k == 11, k == 13));
        run_table();

        // Reset mid-frame; the following frame has no sof.
        for (int k = 1; k <= 6; k++)
            tbl.push_back(mk(k, 1, k == 1, 0, 0, 0, 0, 0, 0, 0));
        run_table();
        do_reset();
        for (int k = 21; k <= 29; k++)
            tbl.push_back(mk(k, 1, 0, 0, k >= 27, k - 6, k - 3, k, k == 27, k == 29));
        run_table();

        // Full-size random frame on the DEPTH=81 instance.
        sel81 = 1'b1;
        do_reset();
        for (int k = 0; k < 243; k++) x[k] = $urandom;
        for (int k = 0; k < 243; k++)
            tbl.push_back(mk(x[k], 1, k == 0, 0, k >= 162,
                             (k >= 162) ? x[k - 162] : 32'd0,
                             (k >= 162) ? x[k - 81]  : 32'd0,
                             x[k], k == 162, k == 242));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
